// File: rtl/mean_stream.sv
// mean_stream: streaming mean of a frame of 2^LOG2_N samples.
//
// Samples arrive LANES per beat over a valid/ready bus. The per-beat lane
// sum is registered and then added into a wide accumulator, so the adder
// tree and the accumulator adder sit in different pipeline stages. The frame
// always ends on the BEATS-th accepted beat. A misplaced or missing in_last
// does not shorten the frame; it only raises out_err for that frame.
//
// Ports:
//   clk       - single clock, rising edge
//   rst       - synchronous active-low reset
//   in_valid  - input beat valid
//   in_ready  - block accepts a beat this cycle
//   in_data   - LANES samples, lane k at [k*WID +: WID], lane 0 earliest
//   in_last   - source marks the final beat of a frame
//   out_valid - frame result available
//   out_ready - consumer accepts the result
//   out_mean  - frame mean (rounded half up or floored, per ROUND)
//   out_err   - framing error seen during the presented frame
module mean_stream #(
    parameter int WID    = 16,
    parameter int LOG2_N = 7,
    parameter int LANES  = 4,
    parameter int SIGNED = 0,
    parameter int ROUND  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*WID-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WID-1:0]       out_mean,
    output logic                 out_err
);

    localparam int N     = 1 << LOG2_N;
    localparam int BEATS = N / LANES;
    // The accumulator holds N full-scale samples without overflow. The
    // rounding constant is also absorbed: the largest sum is 2^AW - N.
    localparam int AW    = WID + LOG2_N;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Half an LSB of the result, i.e. 2^(LOG2_N-1). It is zero when LOG2_N == 0.
    localparam logic [AW-1:0] RND = (ROUND != 0) ? ((AW'(1) << LOG2_N) >> 1) : '0;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        FLUSH = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t          state_q,     state_d;
    logic            in_ready_q,  in_ready_d;
    logic [CW-1:0]   cnt_q,       cnt_d;
    logic            err_q,       err_d;
    logic [AW-1:0]   acc_q,       acc_d;
    logic [AW-1:0]   lane_sum_q,  lane_sum_d;
    logic            lane_vld_q,  lane_vld_d;
    logic            out_valid_q, out_valid_d;
    logic [WID-1:0]  out_mean_q,  out_mean_d;
    logic            out_err_q,   out_err_d;

    logic            accept;
    logic            last_beat;
    logic [AW-1:0]   rnd_sum;
    logic [WID-1:0]  mean;

    // Widen one sample to accumulator width, honouring signedness.
    function automatic logic [AW-1:0] widen(input logic [WID-1:0] x);
        if (SIGNED != 0) return AW'($signed(x));
        else             return AW'(x);
    endfunction

    assign accept    = in_valid & in_ready_q;
    assign last_beat = (cnt_q == CW'(BEATS - 1));

    // Low WID bits of the rounded, shifted accumulator.
    always_comb begin
        rnd_sum = acc_q + RND;
        if (SIGNED != 0) mean = WID'($signed(rnd_sum) >>> LOG2_N);
        else             mean = WID'(rnd_sum >> LOG2_N);
    end

    always_comb begin
        // NOTE: every _d gets a default before any branch. A path that does
        // not assign a combinational signal would otherwise infer a latch.
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_mean_d  = out_mean_q;
        out_err_d   = out_err_q;

        // Stage 1: adder tree over the lanes of the beat being accepted.
        lane_sum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum_d = lane_sum_d + widen(in_data[k*WID +: WID]);
        end
        lane_vld_d = accept;

        // Stage 2: fold the previous beat's lane sum into the accumulator.
        if (lane_vld_q) acc_d = acc_q + lane_sum_q;

        unique case (state_q)
            ACC: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    // in_last must coincide exactly with the final beat.
                    err_d = err_q | (in_last != last_beat);
                    if (last_beat) begin
                        state_d    = FLUSH;
                        in_ready_d = 1'b0;
                        cnt_d      = '0;
                    end
                end
            end
            FLUSH: begin
                // The final lane sum lands in the accumulator this cycle.
                state_d = OUT;
            end
            OUT: begin
                if (!out_valid_q) begin
                    // First OUT cycle: the accumulator is complete, so
                    // capture the result. It is then held through backpressure.
                    out_valid_d = 1'b1;
                    out_mean_d  = mean;
                    out_err_d   = err_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACC;
                    in_ready_d  = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                end
            end
            default: begin
                state_d    = ACC;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // in_ready is registered. During reset it is low, and it rises one edge
    // after rst is released.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments. Every flop then
        // samples its _d value from before the edge, whatever the block order.
        if (!rst) begin
            state_q     <= ACC;
            in_ready_q  <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            lane_sum_q  <= '0;
            lane_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_mean_q  <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_d == ACC;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            lane_sum_q  <= lane_sum_d;
            lane_vld_q  <= lane_vld_d;
            out_valid_q <= out_valid_d;
            out_mean_q  <= out_mean_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_mean  = out_mean_q;
    assign out_err   = out_err_q;

endmodule
